// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu: RV32 load/store unit driving an AXI4-Lite-style master.
// Loads are lane-aligned and extended into load_data; stores get lane-replicated data and byte strobes.
// Ports: req_* request from execute (req_ready = idle), ar/r/aw/w/b master bus channels,
//        load_data/mem_ready/mem_err completion pulse to the register file.
module ysyx_24080014_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [31:0]       load_data,
  output logic              mem_ready,
  output logic              mem_err
);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WREQ, WRESP, DONE
  } state_t;

  localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);

  state_t state, state_n;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wd_q;
  logic              err_q, err_n;
  logic              aw_done, w_done;
  logic              aw_hs, w_hs;
  logic [31:0]       cnt;
  logic              tmo;
  logic              waiting;
  logic              bad_f3, misal, bad_req;
  logic [4:0]        shift;
  logic [31:0]       ld_word, ld_ext;

  // Request legality, evaluated on the live request in IDLE
  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    if (req_is_store)
      bad_f3 = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else
      bad_f3 = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);
    unique case (1'b1)
      req_funct3[1:0] == 2'b01: misal = req_addr[0];
      req_funct3[1:0] == 2'b10: misal = req_addr[1:0] != 2'b00;
      default:                  misal = 1'b0;
    endcase
    bad_req = bad_f3 | misal;
  end

  assign waiting = (state == RADDR) | (state == RDATA) |
                   (state == WREQ)  | (state == WRESP);
  assign tmo     = (TIMEOUT != 0) && (cnt == TLIM);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_comb begin
    state_n = state;
    err_n   = err_q;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          err_n = bad_req;
          if (bad_req)           state_n = DONE;
          else if (req_is_store) state_n = WREQ;
          else                   state_n = RADDR;
        end
      end
      RADDR: begin
        if (arready) begin
          state_n = RDATA;
        end else if (tmo) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      RDATA: begin
        if (rvalid) begin
          state_n = DONE;
          err_n   = rresp != 2'b00;
        end else if (tmo) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      WREQ: begin
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          state_n = WRESP;
        end else if (tmo) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      WRESP: begin
        if (bvalid) begin
          state_n = DONE;
          err_n   = bresp != 2'b00;
        end else if (tmo) begin
          state_n = DONE;
          err_n   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_n;
    end
  end

  // Load lane extraction
  assign shift   = {addr_q[1:0], 3'b000};
  assign ld_word = rdata >> shift;

  always_comb begin
    ld_ext = rdata;
    unique case (f3_q)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_ext = {24'h0, ld_word[7:0]};
      3'b101:  ld_ext = {16'h0, ld_word[15:0]};
      default: ld_ext = rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      f3_q      <= 3'b000;
      wd_q      <= 32'h0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cnt       <= 32'h0;
      load_data <= 32'h0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q <= req_addr;
        f3_q   <= req_funct3;
        wd_q   <= req_wdata;
      end
      // Cleared on every state change so each bus phase gets a full budget
      if (state != state_n)
        cnt <= 32'h0;
      else if (waiting)
        cnt <= cnt + 32'd1;
      if (state == WREQ) begin
        aw_done <= aw_done | aw_hs;
        w_done  <= w_done | w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      // Error responses leave the previous load result in place
      if (state == RDATA && rvalid && rresp == 2'b00)
        load_data <= ld_ext;
    end
  end

  // Store lane replication and strobes
  always_comb begin
    wdata = wd_q;
    wstrb = 4'b1111;
    unique case (f3_q[1:0])
      2'b00: begin
        wdata = {4{wd_q[7:0]}};
        wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        wdata = {2{wd_q[15:0]}};
        wstrb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        wdata = wd_q;
        wstrb = 4'b1111;
      end
    endcase
  end

  assign req_ready = state == IDLE;
  assign araddr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign awaddr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign arvalid   = state == RADDR;
  assign rready    = state == RDATA;
  assign awvalid   = (state == WREQ) & ~aw_done;
  assign wvalid    = (state == WREQ) & ~w_done;
  assign bready    = state == WRESP;
  assign mem_ready = state == DONE;
  assign mem_err   = (state == DONE) & err_q;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Testbench for ysyx_24080014_lsu.
// Table-driven transactions with a reactive slave and a completion scoreboard.
module tb_ysyx_24080014_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] araddr, awaddr;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] load_data;
  logic        mem_ready, mem_err;

  ysyx_24080014_lsu #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .load_data(load_data), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  resp;
    int          aw_dly;
    int          w_dly;
    bit          ar_ok;
    bit          upd;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    int          lat_min;
    int          lat_max;
    int          n_ar;
    int          n_aw;
    int          n_w;
  } vec_t;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    logic        err;
  } sb_t;

  sb_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_ok = 32'h0;
  bit          dirty = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Completion monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_ready === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_mem_ready: got 1 expected 0");
      end else begin
        sb_t e;
        e = sb.pop_front();
        if (mem_err !== e.err ||
            (e.chk && load_data !== e.data)) begin
          fails++;
          $display("FAIL completion: got err=%b data=%h expected err=%b data=%h",
                   mem_err, load_data, e.err, e.data);
        end
      end
    end
  end

  function automatic vec_t mk(
      input logic st, input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp,
      input int aw_dly, input int w_dly, input bit ar_ok, input bit upd,
      input logic [31:0] exp_data, input logic exp_err,
      input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
      input int lat_min, input int lat_max,
      input int n_ar, input int n_aw, input int n_w);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rd = rd;
    v.resp = resp; v.aw_dly = aw_dly; v.w_dly = w_dly;
    v.ar_ok = ar_ok; v.upd = upd; v.exp_data = exp_data;
    v.exp_err = exp_err; v.exp_wdata = exp_wdata; v.exp_strb = exp_strb;
    v.lat_min = lat_min; v.lat_max = lat_max;
    v.n_ar = n_ar; v.n_aw = n_aw; v.n_w = n_w;
    return v;
  endfunction

  task automatic txn(input vec_t v, input string nm);
    sb_t  e;
    int   lat, nar, naw, nw;
    bit   abad, wbad;
    logic [31:0] exp_a;
    exp_a = {v.addr[31:2], 2'b00};
    @(negedge clk);
    chk({nm, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_is_store = v.st;
    req_funct3   = v.f3;
    req_addr     = v.addr;
    req_wdata    = v.wd;
    // Successful loads refresh the held value; anything else keeps it
    if (v.upd) begin
      last_ok = v.exp_data;
      dirty   = 1'b0;
    end else if (!v.st && !v.exp_err) begin
      dirty = 1'b1;
    end
    e.chk  = !dirty && !(!v.st && v.exp_err && v.resp != 2'b00);
    e.data = last_ok;
    e.err  = v.exp_err;
    sb.push_back(e);
    lat = 0; nar = 0; naw = 0; nw = 0; abad = 0; wbad = 0;
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      arready = 1'b0; rvalid = 1'b0; awready = 1'b0;
      wready = 1'b0; bvalid = 1'b0;
      if (mem_ready) begin
        lat = cyc;
      end else begin
        if (arvalid) begin
          nar++;
          if (araddr !== exp_a) abad = 1;
          arready = v.ar_ok;
        end
        if (rready) begin
          rvalid = 1'b1;
          rdata  = v.rd;
          rresp  = v.resp;
        end
        if (awvalid) begin
          naw++;
          if (awaddr !== exp_a) abad = 1;
          awready = (cyc - 1) >= v.aw_dly;
        end
        if (wvalid) begin
          nw++;
          if (wdata !== v.exp_wdata || wstrb !== v.exp_strb) wbad = 1;
          wready = (cyc - 1) >= v.w_dly;
        end
        if (bready) begin
          bvalid = 1'b1;
          bresp  = v.resp;
        end
      end
    end
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0;
    wready = 1'b0; bvalid = 1'b0;
    tests++;
    if (lat < v.lat_min || lat > v.lat_max) begin
      fails++;
      $display("FAIL %s_latency: got %0d expected %0d..%0d",
               nm, lat, v.lat_min, v.lat_max);
    end
    chk({nm, "_n_ar"}, nar, v.n_ar);
    if (v.st) begin
      chk({nm, "_n_aw"}, naw, v.n_aw);
      chk({nm, "_n_w"}, nw, v.n_w);
      chk({nm, "_wlane"}, {31'h0, wbad}, 32'h0);
    end
    chk({nm, "_addr"}, {31'h0, abad}, 32'h0);
  endtask

  vec_t vt[$];

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_is_store = 0; req_funct3 = 0;
    req_addr = 0; req_wdata = 0;
    arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;

    //        st f3      addr          wd            rd            rs aw w ar up exp_data      err wdata         strb     lo hi ar aw w
    vt.push_back(mk(0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 2'd0, 0, 0, 1, 1, 32'hFFFF_FF80, 0, 32'h0, 4'h0, 3, 3, 1, 0, 0));
    vt.push_back(mk(0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 2'd0, 0, 0, 1, 1, 32'h0000_BEEF, 0, 32'h0, 4'h0, 3, 3, 1, 0, 0));
    vt.push_back(mk(0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 2'd0, 0, 0, 1, 1, 32'hFFFF_BEEF, 0, 32'h0, 4'h0, 3, 3, 1, 0, 0));
    vt.push_back(mk(0, 3'b100, 32'h8000_0001, 32'h0, 32'h0000_A500, 2'd0, 0, 0, 1, 1, 32'h0000_00A5, 0, 32'h0, 4'h0, 3, 3, 1, 0, 0));
    vt.push_back(mk(0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 2'd0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 32'h0, 4'h0, 3, 3, 1, 0, 0));
    vt.push_back(mk(0, 3'b010, 32'h8000_0008, 32'h0, 32'h1111_1111, 2'd2, 0, 0, 1, 0, 32'h0,         1, 32'h0, 4'h0, 3, 3, 1, 0, 0));
    vt.push_back(mk(0, 3'b010, 32'h8000_000C, 32'h0, 32'h0BAD_F00D, 2'd0, 0, 0, 1, 1, 32'h0BAD_F00D, 0, 32'h0, 4'h0, 3, 3, 1, 0, 0));
    vt.push_back(mk(1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'h0, 2'd0, 3, 0, 1, 0, 32'h0, 0, 32'hABAB_ABAB, 4'b0010, 6, 6, 0, 4, 1));
    vt.push_back(mk(1, 3'b001, 32'h8000_0002, 32'h0000_CAFE, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0, 0, 32'hCAFE_CAFE, 4'b1100, 3, 3, 0, 1, 1));
    vt.push_back(mk(1, 3'b010, 32'h8000_0010, 32'h1122_3344, 32'h0, 2'd0, 0, 2, 1, 0, 32'h0, 0, 32'h1122_3344, 4'b1111, 5, 5, 0, 1, 3));
    vt.push_back(mk(1, 3'b010, 32'h8000_0014, 32'h5566_7788, 32'h0, 2'd2, 1, 1, 1, 0, 32'h0, 1, 32'h5566_7788, 4'b1111, 4, 4, 0, 2, 2));
    vt.push_back(mk(0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0, 1, 32'h0, 4'h0, 1, 2, 0, 0, 0));
    vt.push_back(mk(1, 3'b001, 32'h8000_0001, 32'h0, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0, 1, 32'h0, 4'h0, 1, 2, 0, 0, 0));
    vt.push_back(mk(0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0, 1, 32'h0, 4'h0, 1, 2, 0, 0, 0));
    vt.push_back(mk(1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 2'd0, 0, 0, 1, 0, 32'h0, 1, 32'h0, 4'h0, 1, 2, 0, 0, 0));
    vt.push_back(mk(0, 3'b010, 32'h8000_0020, 32'h0, 32'h0, 2'd0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 4'h0, 9, 9, 8, 0, 0));

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_valids", {26'h0, arvalid, rready, awvalid, wvalid, bready, mem_ready}, 32'h0);
    chk("rst_mem_err", {31'h0, mem_err}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++)
      txn(vt[i], $sformatf("v%0d", i));

    // Reset while waiting for read data
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h8000_0040;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_arvalid", {31'h0, arvalid}, 32'h1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("rstmid_rready", {31'h0, rready}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_rready_drop", {31'h0, rready}, 32'h0);
    chk("rstmid_req_ready", {31'h0, req_ready}, 32'h1);
    last_ok = 32'h0;
    dirty = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_pulse", {31'h0, mem_ready}, 32'h0);
    end
    chk("rstmid_load_data", load_data, 32'h0);

    txn(mk(0, 3'b010, 32'h8000_0044, 32'h0, 32'h55AA_00FF, 2'd0, 0, 0, 1, 1,
           32'h55AA_00FF, 0, 32'h0, 4'h0, 3, 3, 1, 0, 0), "post_rst_lw");

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
